// File: rtl/trace_dispatch_queue.sv
// trace_dispatch_queue: validates trace records and holds them in a circular buffer until the cycle counter reaches each timestamp.
// Define TRACE_SKIP_IDLE_EN to let the cycle counter jump straight to a far-future head timestamp.
module trace_dispatch_queue #(
  parameter int ADDR_WIDTH       = 36,
  parameter int CMD_WIDTH        = 2,
  parameter int TIME_WIDTH       = 32,
  parameter int DEPTH            = 16,
  parameter int MAX_OPS_PER_TIME = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [TIME_WIDTH-1:0]      in_time,
  input  logic [CMD_WIDTH-1:0]       in_cmd,
  input  logic [ADDR_WIDTH-1:0]      in_addr,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TIME_WIDTH-1:0]      out_time,
  output logic [CMD_WIDTH-1:0]       out_cmd,
  output logic [ADDR_WIDTH-1:0]      out_addr,
  output logic [TIME_WIDTH-1:0]      cycle_count,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty,
  output logic                       err_cmd,
  output logic                       err_order,
  output logic                       err_burst,
  input  logic                       err_clr,
  output logic                       done
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(MAX_OPS_PER_TIME + 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [TIME_WIDTH-1:0] time_mem [DEPTH];
  logic [CMD_WIDTH-1:0]  cmd_mem  [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [TIME_WIDTH-1:0] last_time, head_time, count_nx;
  logic [BW-1:0] burst_cnt;
  logic hs, bad_cmd, bad_order, bad_burst, push, pop, active, skip;
  assign head_time = time_mem[rd_ptr];
  assign full      = level == LW'(DEPTH);
  assign empty     = level == '0;
  assign in_ready  = rst_n && !full && (state == IDLE || state == RUN);
  assign hs        = in_valid && in_ready;
  assign bad_cmd   = in_cmd == CMD_WIDTH'(3);
  assign bad_order = !bad_cmd && in_time < last_time;
  assign bad_burst = !bad_cmd && !bad_order && in_time == last_time && burst_cnt == BW'(MAX_OPS_PER_TIME);
  assign push      = hs && !bad_cmd && !bad_order && !bad_burst;
  assign out_valid = !empty && head_time <= cycle_count;
  assign pop       = out_valid && out_ready;
  assign out_time  = empty ? '0 : head_time;
  assign out_cmd   = empty ? '0 : cmd_mem[rd_ptr];
  assign out_addr  = empty ? '0 : addr_mem[rd_ptr];
  assign active    = state == RUN || state == DRAIN;
  assign done      = state == DONE;
`ifdef TRACE_SKIP_IDLE_EN
  // widened compare so cycle_count+1 cannot wrap at all-ones
  assign skip = !empty && {1'b0, head_time} > {1'b0, cycle_count} + (TIME_WIDTH + 1)'(1);
`else
  assign skip = 1'b0;
`endif
  assign count_nx = !active ? cycle_count :
                    skip ? head_time :
                    (&cycle_count) ? cycle_count : cycle_count + TIME_WIDTH'(1);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (hs) state_nx = in_last ? DRAIN : RUN;
      RUN:     if (hs && in_last) state_nx = DRAIN;
      DRAIN:   if (empty) state_nx = DONE;
      default: state_nx = DONE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      cycle_count <= '0;
      last_time   <= '0;
      burst_cnt   <= '0;
      err_cmd     <= 1'b0;
      err_order   <= 1'b0;
      err_burst   <= 1'b0;
    end else begin
      state       <= state_nx;
      cycle_count <= count_nx;
      level       <= level + LW'(push) - LW'(pop);
      err_cmd     <= (hs && bad_cmd) || (err_cmd && !err_clr);
      err_order   <= (hs && bad_order) || (err_order && !err_clr);
      err_burst   <= (hs && bad_burst) || (err_burst && !err_clr);
      if (push) begin
        wr_ptr    <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
        last_time <= in_time;
        burst_cnt <= (in_time == last_time) ? burst_cnt + BW'(1) : BW'(1);
      end
      if (pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      time_mem[wr_ptr] <= in_time;
      cmd_mem[wr_ptr]  <= in_cmd;
      addr_mem[wr_ptr] <= in_addr;
    end
  end
endmodule

// File: tb/tb_trace_dispatch_queue.sv
// tb_trace_dispatch_queue: directed scenarios plus random traffic compared every cycle against a queue-based reference model.
module tb_trace_dispatch_queue;
  localparam int AW = 36, CW = 2, TW = 32, D = 16, MX = 4;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_last = 0, out_ready = 0, err_clr = 0;
  logic [TW-1:0] in_time = 0;
  logic [CW-1:0] in_cmd = 0;
  logic [AW-1:0] in_addr = 0;
  logic in_ready, out_valid, full, empty, err_cmd, err_order, err_burst, done;
  logic [TW-1:0] out_time, cycle_count;
  logic [CW-1:0] out_cmd;
  logic [AW-1:0] out_addr;
  logic [$clog2(D+1)-1:0] level;
  always #5 clk = ~clk;
  trace_dispatch_queue #(.ADDR_WIDTH(AW), .CMD_WIDTH(CW), .TIME_WIDTH(TW), .DEPTH(D), .MAX_OPS_PER_TIME(MX)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_time(in_time),
    .in_cmd(in_cmd), .in_addr(in_addr), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_time(out_time), .out_cmd(out_cmd), .out_addr(out_addr), .cycle_count(cycle_count), .level(level),
    .full(full), .empty(empty), .err_cmd(err_cmd), .err_order(err_order), .err_burst(err_burst),
    .err_clr(err_clr), .done(done));
  typedef struct {logic [TW-1:0] t; logic [CW-1:0] c; logic [AW-1:0] a;} rec_t;
  rec_t q[$];
  longint m_last, m_cyc;
  int m_bcnt;
  bit started, got_last, finished, e_cmd, e_order, e_burst;
  longint pop_cyc[$], pop_t[$], pop_a[$];
  int checks = 0, errors = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    q.delete();
    m_last = 0; m_cyc = 0; m_bcnt = 0;
    started = 0; got_last = 0; finished = 0;
    e_cmd = 0; e_order = 0; e_burst = 0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; in_valid = 1; in_last = 0; out_ready = 0; err_clr = 0;
    #1 check("rst_in_ready", 64'(in_ready), 0);
    @(negedge clk);
    rst_n = 1; in_valid = 0;
    model_reset();
    pop_cyc.delete(); pop_t.delete(); pop_a.delete();
  endtask
  task automatic step(input bit v, input longint t, input int c, input longint a, input bit l, input bit ordy, input bit clr);
    bit rdy, ov, hs, pop, nc, no, nb;
    rec_t r;
    @(negedge clk);
    in_valid = v; in_time = TW'(t); in_cmd = CW'(c); in_addr = AW'(a); in_last = l; out_ready = ordy; err_clr = clr;
    #1;
    rdy = !got_last && q.size() < D;
    ov = q.size() > 0 && longint'(q[0].t) <= m_cyc;
    check("in_ready", 64'(in_ready), 64'(rdy));
    check("out_valid", 64'(out_valid), 64'(ov));
    check("out_time", 64'(out_time), q.size() > 0 ? 64'(q[0].t) : 64'(0));
    check("out_cmd", 64'(out_cmd), q.size() > 0 ? 64'(q[0].c) : 64'(0));
    check("out_addr", 64'(out_addr), q.size() > 0 ? 64'(q[0].a) : 64'(0));
    check("level", 64'(level), 64'(q.size()));
    check("full", 64'(full), 64'(q.size() == D));
    check("empty", 64'(empty), 64'(q.size() == 0));
    check("cycle_count", 64'(cycle_count), 64'(m_cyc));
    check("err_flags", 64'({err_cmd, err_order, err_burst}), 64'({e_cmd, e_order, e_burst}));
    check("done", 64'(done), 64'(finished));
    if (out_valid && ordy) begin
      pop_cyc.push_back(longint'(cycle_count)); pop_t.push_back(longint'(out_time)); pop_a.push_back(longint'(out_addr));
    end
    hs = v && rdy;
    pop = ov && ordy;
    if (started && !finished) begin
`ifdef TRACE_SKIP_IDLE_EN
      if (q.size() > 0 && longint'(q[0].t) > m_cyc + 1) m_cyc = longint'(q[0].t);
      else
`endif
      if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
    end
    if (got_last && q.size() == 0) finished = 1;
    nc = 0; no = 0; nb = 0;
    if (pop) void'(q.pop_front());
    if (hs) begin
      started = 1;
      if (l) got_last = 1;
      if (c == 3) nc = 1;
      else if (t < m_last) no = 1;
      else if (t == m_last && m_bcnt == MX) nb = 1;
      else begin
        m_bcnt = (t == m_last) ? m_bcnt + 1 : 1;
        m_last = t;
        r.t = TW'(t); r.c = CW'(c); r.a = AW'(a);
        q.push_back(r);
      end
    end
    e_cmd = nc || (e_cmd && !clr);
    e_order = no || (e_order && !clr);
    e_burst = nb || (e_burst && !clr);
  endtask
  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, ordy, 0);
  endtask
  initial begin
    longint t;
    do_reset();
    idle(1, 0);
    check("rst_level", 64'(level), 0);
    check("rst_cycle", 64'(cycle_count), 0);
    // ordered release
    step(1, 5, 0, 36'h0_1FF9_7000, 0, 1, 0);
    step(1, 8, 1, 36'h1_0000_0040, 0, 1, 0);
    idle(12, 1);
    check("rel_pops", 64'(pop_t.size()), 2);
    check("rel0_time", 64'(pop_t[0]), 5);
    check("rel1_addr", 64'(pop_a[1]), 64'h1_0000_0040);
`ifndef TRACE_SKIP_IDLE_EN
    check("rel0_cyc", 64'(pop_cyc[0]), 5);
    check("rel1_cyc", 64'(pop_cyc[1]), 8);
`endif
    check("rel_err", 64'({err_cmd, err_order, err_burst}), 0);
    // order violation
    do_reset();
    step(1, 10, 0, 1, 0, 0, 0);
    step(1, 7, 0, 2, 0, 0, 0);
    idle(1, 0);
    check("ord_err", 64'(err_order), 1);
    check("ord_level", 64'(level), 1);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(1, 0);
    check("ord_clr", 64'(err_order), 0);
    // burst limit
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 3, 1, 64'h30 + i, 0, 0, 0);
    step(1, 4, 2, 64'h40, 0, 0, 0);
    idle(1, 0);
    check("burst_err", 64'(err_burst), 1);
    check("burst_level", 64'(level), 5);
    // illegal command
    do_reset();
    step(1, 2, 3, 64'h99, 0, 0, 0);
    idle(1, 0);
    check("cmd_err", 64'(err_cmd), 1);
    check("cmd_order", 64'(err_order), 0);
    check("cmd_level", 64'(level), 0);
    // full and pointer wrap
    do_reset();
    for (int i = 0; i < 16; i++) step(1, i / 4, i % 3, 64'h100 + i, 0, 0, 0);
    idle(1, 0);
    check("full_flag", 64'(full), 1);
    check("full_ready", 64'(in_ready), 0);
    idle(6, 1);
    for (int i = 0; i < 16; i++) step(1, 4 + i / 4, i % 3, 64'h200 + i, 0, 1, 0);
    idle(30, 1);
    check("wrap_pops", 64'(pop_a.size()), 32);
    for (int i = 0; i < 32 && i < pop_a.size(); i++)
      check("wrap_order", 64'(pop_a[i]), i < 16 ? 64'h100 + i : 64'h200 + i - 16);
    // reset mid-operation discards contents
    step(1, 100, 0, 5, 0, 0, 0);
    do_reset();
    idle(1, 0);
    check("midrst_level", 64'(level), 0);
    // end of trace
    step(1, 1000, 0, 64'hABC, 1, 1, 0);
    for (int i = 0; i < 1100 && !done; i++) idle(1, 1);
    check("eot_done", 64'(done), 1);
    check("eot_ready", 64'(in_ready), 0);
    check("eot_pops", 64'(pop_cyc.size()), 1);
    check("eot_cyc", 64'(pop_cyc[0]), 1000);
    // random traffic, each episode starting from reset
    for (int e = 0; e < 8; e++) begin
      do_reset();
      for (int i = 0; i < 150; i++) begin
        t = ($urandom_range(0, 9) == 0 && m_last > 0) ? m_last - 1 : m_last + $urandom_range(0, 2);
        step($urandom_range(0, 3) != 0, t, $urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2),
             {$urandom(), $urandom()}, i > 80 && $urandom_range(0, 19) == 0,
             got_last || $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
